// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 to MC-10 key matrix emulator.
// Scancodes are PS/2 set 2; matrix coordinates are {column, row}.
package ps2_kbd_pkg;

  localparam int COL_W = 3;
  localparam int ROW_W = 3;

  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_Q      = 8'h15;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ESC    = 8'h76;

  localparam logic [COL_W-1:0] SHIFT_COL = 3'd7;
  localparam logic [ROW_W-1:0] SHIFT_ROW = 3'd6;

  typedef struct packed {
    logic             make;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             lsh;
    logic             rsh;
  } kbd_evt_t;

  localparam int EVT_W = $bits(kbd_evt_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_HOLD  = 2'd2
  } apply_st_t;

endpackage

// File: rtl/ps2_matrix_kbd_if.sv
// Bus between the keyboard emulator and its host: PS/2 events in, matrix scan lines, status.
interface ps2_matrix_kbd_if #(
  parameter int NCOLS = 8,
  parameter int NROWS = 7
);
  logic [10:0]      ps2_key;
  logic [NCOLS-1:0] kr;
  logic [NROWS-1:0] rows;
  logic             overflow;
  logic             busy;

  modport master (output ps2_key, output kr, input rows, input overflow, input busy);
  modport slave  (input ps2_key, input kr, output rows, output overflow, output busy);
endinterface

// File: rtl/ps2_keymap.sv
// Combinational PS/2 set-2 to MC-10 matrix lookup; retarget a machine by editing this table only.
// Table entries are 6-bit octal {col,row}, e.g. 6'o13 = column 1, row 3.
module ps2_keymap
  import ps2_kbd_pkg::*;
(
  input  logic             i_ext,
  input  logic [7:0]       i_code,
  output logic             o_valid,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_lsh,
  output logic             o_rsh
);

  logic [5:0] w_cr;

  always_comb begin
    o_valid = 1'b1;
    w_cr    = 6'o00;
    o_lsh   = 1'b0;
    o_rsh   = 1'b0;
    case ({i_ext, i_code})
      9'h054:          w_cr = 6'o00;
      {1'b0, SC_A}:    w_cr = 6'o10;
      9'h032:          w_cr = 6'o20;
      9'h021:          w_cr = 6'o30;
      9'h023:          w_cr = 6'o40;
      9'h024:          w_cr = 6'o50;
      9'h02B:          w_cr = 6'o60;
      9'h034:          w_cr = 6'o70;
      9'h033:          w_cr = 6'o01;
      9'h043:          w_cr = 6'o11;
      9'h03B:          w_cr = 6'o21;
      9'h042:          w_cr = 6'o31;
      9'h04B:          w_cr = 6'o41;
      9'h03A:          w_cr = 6'o51;
      9'h031:          w_cr = 6'o61;
      9'h044:          w_cr = 6'o71;
      9'h04D:          w_cr = 6'o02;
      {1'b0, SC_Q}:    w_cr = 6'o12;
      9'h02D:          w_cr = 6'o22;
      9'h01B:          w_cr = 6'o32;
      9'h02C:          w_cr = 6'o42;
      9'h03C:          w_cr = 6'o52;
      9'h02A:          w_cr = 6'o62;
      9'h01D:          w_cr = 6'o72;
      9'h022:          w_cr = 6'o03;
      9'h035:          w_cr = 6'o13;
      9'h01A:          w_cr = 6'o23;
      {1'b0, SC_ENTER}: w_cr = 6'o63;
      {1'b0, SC_SPACE}: w_cr = 6'o73;
      9'h045:          w_cr = 6'o04;
      9'h016:          w_cr = 6'o14;
      9'h01E:          w_cr = 6'o24;
      9'h026:          w_cr = 6'o34;
      9'h025:          w_cr = 6'o44;
      9'h02E:          w_cr = 6'o54;
      9'h036:          w_cr = 6'o64;
      9'h03D:          w_cr = 6'o74;
      9'h03E:          w_cr = 6'o05;
      9'h046:          w_cr = 6'o15;
      9'h052:          w_cr = 6'o25;
      9'h04C:          w_cr = 6'o35;
      9'h041:          w_cr = 6'o45;
      9'h04E:          w_cr = 6'o55;
      9'h049:          w_cr = 6'o65;
      9'h04A:          w_cr = 6'o75;
      {1'b0, SC_CTRL}: w_cr = 6'o06;
      {1'b0, SC_ESC}:  w_cr = 6'o26;
      {1'b0, SC_LSHIFT}: begin
        w_cr  = {SHIFT_COL, SHIFT_ROW};
        o_lsh = 1'b1;
      end
      {1'b0, SC_RSHIFT}: begin
        w_cr  = {SHIFT_COL, SHIFT_ROW};
        o_rsh = 1'b1;
      end
      // E0-prefixed keys: keypad enter, right ctrl, keypad slash
      {1'b1, SC_ENTER}: w_cr = 6'o63;
      {1'b1, SC_CTRL}:  w_cr = 6'o06;
      9'h14A:           w_cr = 6'o75;
      default:          o_valid = 1'b0;
    endcase
  end

  assign o_col = w_cr[5:3];
  assign o_row = w_cr[2:0];

endmodule

// File: rtl/ps2_matrix_kbd.sv
// PS/2 event stream to registered MC-10 key matrix, with an event FIFO and a minimum hold
// time per matrix change so that short press/release pairs survive slow CPU scans.
module ps2_matrix_kbd
  import ps2_kbd_pkg::*;
#(
  parameter int          NCOLS       = 8,
  parameter int          NROWS       = 7,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] HOLD_CYCLES = 16'd20000
) (
  input logic              clk,
  input logic              reset_n,
  ps2_matrix_kbd_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic             w_map_valid;
  logic [COL_W-1:0] w_map_col;
  logic [ROW_W-1:0] w_map_row;
  logic             w_map_lsh;
  logic             w_map_rsh;

  ps2_keymap u_keymap (
    .i_ext   (bus.ps2_key[8]),
    .i_code  (bus.ps2_key[7:0]),
    .o_valid (w_map_valid),
    .o_col   (w_map_col),
    .o_row   (w_map_row),
    .o_lsh   (w_map_lsh),
    .o_rsh   (w_map_rsh)
  );

  logic     r_tog;
  logic     r_armed;
  logic     r_cap_vld;
  kbd_evt_t r_cap;
  logic     w_evt;

  // The first cycle out of reset only learns the toggle level.
  assign w_evt = r_armed && (bus.ps2_key[10] != r_tog) && w_map_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tog     <= 1'b0;
      r_armed   <= 1'b0;
      r_cap_vld <= 1'b0;
      r_cap     <= '0;
    end else begin
      r_tog     <= bus.ps2_key[10];
      r_armed   <= 1'b1;
      r_cap_vld <= w_evt;
      if (w_evt) begin
        r_cap <= '{make: bus.ps2_key[9], col: w_map_col, row: w_map_row,
                   lsh: w_map_lsh, rsh: w_map_rsh};
      end
    end
  end

  logic [EVT_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign w_push  = r_cap_vld && (!w_full || w_pop);
  assign w_drop  = r_cap_vld && !w_push;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[PTR_W-1:0]] <= r_cap;
    end
  end

  apply_st_t                   r_state;
  apply_st_t                   w_state_next;
  kbd_evt_t                    r_cur;
  logic [15:0]                 r_hold_cnt;
  logic [NCOLS-1:0][NROWS-1:0] r_mat;
  logic                        r_lsh_q;
  logic                        r_rsh_q;
  logic                        r_ovf;

  logic w_is_shift;
  logic w_lsh_new;
  logic w_rsh_new;
  logic w_cell_old;
  logic w_cell_new;
  logic w_change;
  logic w_write;
  logic w_load;
  logic w_dec;

  // The shift cell is the OR of both shift keys, so one release can leave it set.
  assign w_is_shift = r_cur.lsh | r_cur.rsh;
  assign w_lsh_new  = r_cur.lsh ? r_cur.make : r_lsh_q;
  assign w_rsh_new  = r_cur.rsh ? r_cur.make : r_rsh_q;
  assign w_cell_old = r_mat[r_cur.col][r_cur.row];
  assign w_cell_new = w_is_shift ? (w_lsh_new | w_rsh_new) : r_cur.make;
  assign w_change   = (w_cell_new != w_cell_old);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_state_next = ST_APPLY;
      ST_APPLY: w_state_next = w_change ? ST_HOLD : ST_IDLE;
      ST_HOLD:  if (r_hold_cnt == 16'd0) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_pop   = (r_state == ST_IDLE) && !w_empty;
    w_write = (r_state == ST_APPLY);
    w_load  = (r_state == ST_APPLY) && w_change;
    w_dec   = (r_state == ST_HOLD) && (r_hold_cnt != 16'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cur      <= '0;
      r_hold_cnt <= '0;
      r_mat      <= '0;
      r_lsh_q    <= 1'b0;
      r_rsh_q    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_cur    <= kbd_evt_t'(r_fifo[r_rd_ptr[PTR_W-1:0]]);
      end
      if (w_drop) r_ovf <= 1'b1;
      if (w_write) begin
        r_mat[r_cur.col][r_cur.row] <= w_cell_new;
        if (w_is_shift) begin
          r_lsh_q <= w_lsh_new;
          r_rsh_q <= w_rsh_new;
        end
      end
      if (w_load) begin
        r_hold_cnt <= HOLD_CYCLES - 16'd1;
      end else if (w_dec) begin
        r_hold_cnt <= r_hold_cnt - 16'd1;
      end
    end
  end

  genvar gi, gc;
  generate
    for (gi = 0; gi < NROWS; gi++) begin : g_row
      logic [NCOLS-1:0] w_col_bits;
      for (gc = 0; gc < NCOLS; gc++) begin : g_col
        assign w_col_bits[gc] = r_mat[gc][gi];
      end
      assign bus.rows[gi] = ~|(~bus.kr & w_col_bits);
    end
  endgenerate

  assign bus.overflow = r_ovf;
  assign bus.busy     = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_ps2_matrix_kbd.sv
// Self-checking bench: directed table, multi-cycle corner sequences, then random events
// against a per-key matrix model.
module tb_ps2_matrix_kbd;

  localparam int          NC = 8;
  localparam int          NR = 7;
  localparam logic [15:0] HC = 16'd10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ps2_matrix_kbd_if #(.NCOLS(NC), .NROWS(NR)) bus ();

  ps2_matrix_kbd #(
    .NCOLS(NC), .NROWS(NR), .FIFO_DEPTH(4), .HOLD_CYCLES(HC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic ext, input logic mk, input logic [7:0] code);
    bus.ps2_key = {~bus.ps2_key[10], mk, ext, code};
  endtask

  task automatic settle(input string name);
    int n = 0;
    step();
    step();
    while (bus.busy && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL %s: busy still 1 after 200 cycles, expected 0", name);
    end
  endtask

  task automatic scan(input logic [7:0] k, output logic [6:0] r);
    bus.kr = k;
    #1;
    r = bus.rows;
  endtask

  // Directed table
  typedef struct {
    bit         send_evt;
    logic       ext;
    logic       mk;
    logic [7:0] code;
    logic [7:0] kr;
    logic [6:0] exp_rows;
  } vec_t;
  vec_t vt[$];

  // Reference keymap (required entries plus some codes with no key)
  typedef struct {
    logic       ext;
    logic [7:0] code;
    int         col;
    int         row;
    int         kind;  // 0 no key, 1 plain key, 2 left shift, 3 right shift
  } key_t;
  key_t keys[12];

  bit model_key [NC][NR];
  bit m_lsh, m_rsh;

  function automatic logic [6:0] model_rows(input logic [7:0] k);
    logic [6:0] r = 7'h7F;
    for (int c = 0; c < NC; c++) begin
      for (int rr = 0; rr < NR; rr++) begin
        bit pressed = model_key[c][rr] || (c == 7 && rr == 6 && (m_lsh || m_rsh));
        if (!k[c] && pressed) r[rr] = 1'b0;
      end
    end
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [6:0] rv;
    int         low_cnt;
    bit         bad;
    int         first_seen [7];
    logic [7:0] k;

    vt.push_back('{1, 1'b0, 1'b1, 8'h1C, 8'hFD, 7'h7E});
    vt.push_back('{0, 1'b0, 1'b0, 8'h00, 8'hFE, 7'h7F});
    vt.push_back('{1, 1'b0, 1'b1, 8'h5A, 8'hBF, 7'h77});
    vt.push_back('{1, 1'b0, 1'b0, 8'h1C, 8'hFD, 7'h7F});
    vt.push_back('{1, 1'b0, 1'b1, 8'h29, 8'h3F, 7'h77});
    vt.push_back('{1, 1'b0, 1'b0, 8'h5A, 8'hBF, 7'h7F});
    vt.push_back('{1, 1'b1, 1'b1, 8'h5A, 8'hBF, 7'h77});
    vt.push_back('{1, 1'b0, 1'b1, 8'h14, 8'hFE, 7'h3F});
    vt.push_back('{1, 1'b0, 1'b1, 8'h76, 8'hFA, 7'h3F});
    vt.push_back('{0, 1'b0, 1'b0, 8'h00, 8'hFF, 7'h7F});
    vt.push_back('{1, 1'b0, 1'b1, 8'h15, 8'hFD, 7'h7B});
    vt.push_back('{1, 1'b0, 1'b1, 8'h07, 8'h00, 7'h33});
    vt.push_back('{1, 1'b1, 1'b0, 8'h5A, 8'h7F, 7'h77});
    vt.push_back('{1, 1'b0, 1'b0, 8'h29, 8'h00, 7'h3B});
    vt.push_back('{1, 1'b0, 1'b0, 8'h14, 8'hFE, 7'h7F});
    vt.push_back('{1, 1'b0, 1'b0, 8'h76, 8'h00, 7'h7B});
    vt.push_back('{1, 1'b0, 1'b0, 8'h15, 8'h00, 7'h7F});

    keys[0]  = '{1'b0, 8'h1C, 1, 0, 1};
    keys[1]  = '{1'b0, 8'h15, 1, 2, 1};
    keys[2]  = '{1'b0, 8'h5A, 6, 3, 1};
    keys[3]  = '{1'b0, 8'h29, 7, 3, 1};
    keys[4]  = '{1'b0, 8'h14, 0, 6, 1};
    keys[5]  = '{1'b0, 8'h76, 2, 6, 1};
    keys[6]  = '{1'b0, 8'h12, 7, 6, 2};
    keys[7]  = '{1'b0, 8'h59, 7, 6, 3};
    keys[8]  = '{1'b1, 8'h5A, 6, 3, 1};
    keys[9]  = '{1'b0, 8'h07, 0, 0, 0};
    keys[10] = '{1'b1, 8'h1C, 0, 0, 0};
    keys[11] = '{1'b1, 8'h12, 0, 0, 0};

    // Reset with the toggle high: no event may be generated
    bus.ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
    bus.kr = 8'hFF;
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (5) step();
    scan(8'h00, rv);
    chk("reset rows", rv, 7'h7F);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset overflow", bus.overflow, 1'b0);

    // Capture-to-matrix latency
    bus.kr = 8'hFD;
    send(1'b0, 1'b1, 8'h1C);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("latency cycle %0d", i), bus.rows, 7'h7F);
    end
    step();
    chk("latency cycle 4", bus.rows, 7'h7E);
    settle("latency make");
    send(1'b0, 1'b0, 8'h1C);
    settle("latency break");

    foreach (vt[i]) begin
      if (vt[i].send_evt) begin
        send(vt[i].ext, vt[i].mk, vt[i].code);
        settle($sformatf("vec %0d", i));
      end
      scan(vt[i].kr, rv);
      chk($sformatf("vec %0d rows", i), rv, vt[i].exp_rows);
    end

    // Make then break on consecutive toggles: set for HOLD_CYCLES in HOLD plus pop and apply
    bus.kr = 8'hFD;
    send(1'b0, 1'b1, 8'h1C);
    step();
    send(1'b0, 1'b0, 8'h1C);
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!bus.rows[0]) low_cnt++;
    end
    chk("hold length", low_cnt, 32'(HC) + 2);
    chk("hold break applied", bus.rows, 7'h7F);
    chk("hold busy", bus.busy, 1'b0);

    // Left and right shift tracked separately
    bus.kr = 8'h7F;
    send(1'b0, 1'b1, 8'h12);
    settle("lshift make");
    chk("lshift rows", bus.rows, 7'h3F);
    send(1'b0, 1'b1, 8'h59);
    settle("rshift make");
    chk("both shift rows", bus.rows, 7'h3F);
    send(1'b0, 1'b0, 8'h12);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rows[6] !== 1'b0) bad = 1'b1;
    end
    chk("shift held through lshift break", bad, 1'b0);
    chk("shift busy", bus.busy, 1'b0);
    send(1'b0, 1'b0, 8'h59);
    settle("rshift break");
    chk("shift released", bus.rows, 7'h7F);

    // Typematic repeat: no HOLD on the second make
    bus.kr = 8'hFD;
    send(1'b0, 1'b1, 8'h15);
    settle("typ first");
    chk("typ rows", bus.rows, 7'h7B);
    send(1'b0, 1'b1, 8'h15);
    step();
    step();
    chk("typ busy after push", bus.busy, 1'b1);
    step();
    chk("typ busy after pop", bus.busy, 1'b1);
    step();
    chk("typ busy one after pop", bus.busy, 1'b0);
    chk("typ rows kept", bus.rows, 7'h7B);
    send(1'b0, 1'b0, 8'h15);
    settle("typ break");

    // Six makes back to back (A..F on row 0): five applied in order, sixth dropped
    begin
      logic [7:0] codes [6];
      codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h21;
      codes[3] = 8'h23; codes[4] = 8'h24; codes[5] = 8'h2B;
      for (int i = 0; i < 6; i++) begin
        send(1'b0, 1'b1, codes[i]);
        step();
      end
      for (int c = 0; c < 7; c++) first_seen[c] = -1;
      for (int cyc = 0; cyc < 150; cyc++) begin
        for (int c = 1; c <= 6; c++) begin
          bus.kr = ~(8'h01 << c);
          #1;
          if (!bus.rows[0] && first_seen[c] < 0) first_seen[c] = cyc;
        end
        step();
      end
      chk("ovf flag", bus.overflow, 1'b1);
      chk("ovf busy", bus.busy, 1'b0);
      chk("ovf A applied", first_seen[1] >= 0, 1'b1);
      for (int c = 2; c <= 5; c++)
        chk($sformatf("ovf col %0d in order", c), first_seen[c] > first_seen[c-1], 1'b1);
      chk("ovf F dropped", first_seen[6], 32'hFFFF_FFFF);
      for (int i = 0; i < 5; i++) begin
        send(1'b0, 1'b0, codes[i]);
        settle("ovf release");
      end
      chk("ovf sticky", bus.overflow, 1'b1);
    end

    // Reset during HOLD with an event queued
    send(1'b0, 1'b1, 8'h34);
    repeat (5) step();
    send(1'b0, 1'b1, 8'h33);
    repeat (2) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (6) step();
    scan(8'h00, rv);
    chk("midreset rows", rv, 7'h7F);
    chk("midreset overflow", bus.overflow, 1'b0);
    chk("midreset busy", bus.busy, 1'b0);
    send(1'b0, 1'b1, 8'h21);
    settle("post reset make");
    scan(8'hF7, rv);
    chk("post reset C", rv, 7'h7E);
    send(1'b0, 1'b0, 8'h21);
    settle("post reset break");

    // Random events against the model
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) model_key[c][r] = 1'b0;
    m_lsh = 1'b0;
    m_rsh = 1'b0;
    for (int it = 0; it < 60; it++) begin
      int   idx = int'($urandom_range(0, 11));
      logic mk  = 1'($urandom_range(0, 1));
      send(keys[idx].ext, mk, keys[idx].code);
      settle($sformatf("rand %0d", it));
      case (keys[idx].kind)
        1: model_key[keys[idx].col][keys[idx].row] = mk;
        2: m_lsh = mk;
        3: m_rsh = mk;
        default: ;
      endcase
      k = 8'($urandom);
      scan(k, rv);
      chk($sformatf("rand %0d kr=%02h", it, k), rv, model_rows(k));
    end
    chk("rand overflow", bus.overflow, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
